control_flow_seq: RTL and testbench
===================================

// Module: control_flow_seq
// PURPOSE
//  Parametrised successor of the accumulator-machine control unit. Decodes the IR opcode and
//  sequences fetch/decode/execute/writeback, driving PC, IR, accumulator, ALU and data-memory
//  controls. Adds configurable ALU latency, a mem_ack handshake with timeout, HALT, and an
//  illegal-opcode trap. Sits between IR/flag registers and the datapath of the generalised CPU.
// PARAMETERS
//  OPW      8   opcode width (>=5); opcode[OPW-1] is the class bit (0 = ALU, 1 = control)
//  ALU_LAT  1   EXEC cycles for ALU ops, 1..15 (MUL may need more)
//  MEM_TO   16  max cycles waiting for mem_ack before timeout, 2..255
// PORTS
//  clk      in   1    rising-edge clock
//  rstn     in   1    synchronous reset, ACTIVE-HIGH (1 = reset) despite the name
//  opcode   in   OPW  opcode from IR, valid from DECODE onward
//  z        in   1    zero flag
//  c        in   1    carry flag
//  mem_ack  in   1    data memory completed current rd_en/wr_en access
//  loadIR   out  1    load IR from instruction bus
//  incPC    out  1    PC <= PC+1
//  loadPC   out  1    PC <= selected jump target
//  selPC    out  1    jump target: 0 = IR immediate, 1 = memory read data
//  selacc   out  2    acc source: 00 ALU, 01 immediate, 10 memory data, 11 hold
//  loadacc  out  1    accumulator write enable
//  rd_en    out  1    data memory read request
//  wr_en    out  1    data memory write request (acc -> mem)
//  alu_op   out  OPW  ALU operation (opcode during EXEC/WB, else 0)
//  halted   out  1    sticky, FSM in HALT
//  illegal  out  1    sticky, HALT entered via illegal opcode
//  timeout  out  1    sticky, HALT entered via mem_ack timeout
// BEHAVIOUR
//  Reset (rstn=1 at posedge): state FETCH, counters 0, every output 0, selacc=11. Reset aborts
//   any instruction mid-flight (incl. MEM_WAIT); first FETCH is the cycle after rstn falls.
//  States: FETCH, DECODE, EXEC, WB, MEM_WAIT, HALT. All outputs registered from next state.
//  FETCH (1 cyc): loadIR=1, incPC=1 -> DECODE.
//  DECODE (1 cyc): classify opcode; opcode==0 (NOP) -> FETCH; all-ones -> HALT;
//   undefined -> HALT with illegal=1; else -> EXEC.
//  ALU class (MSB=0), low value 1,2,3,5..10 (ADD,SUB,MUL,NOT,OR,XOR,AND,SHL,SHR; 4 undefined):
//   EXEC held ALU_LAT cycles via counter, alu_op=opcode; WB 1 cycle: alu_op=opcode,
//   selacc=00, loadacc=1 -> FETCH. Total 3+ALU_LAT cycles (4 at default).
//  Control class (MSB=1), low (OPW-1) bits value:
//   1 MOV imm : EXEC selacc=01, loadacc=1 -> FETCH (3 cyc).
//   2 MOV addr/4 LOAD: EXEC rd_en=1 -> MEM_WAIT; on mem_ack: selacc=10, loadacc=1 -> FETCH.
//   3 STORE   : EXEC wr_en=1 -> MEM_WAIT; on mem_ack -> FETCH.
//   5/6 JC, 7/8 JZ, 9/10 JNC, 11/12 JNZ (odd = imm, even = addr). Flags sampled on entry
//    to EXEC only. Not taken: -> FETCH, no loadPC, no rd_en. Taken imm: selPC=0, loadPC=1
//    -> FETCH. Taken addr: rd_en=1 -> MEM_WAIT; on mem_ack selPC=1, loadPC=1 -> FETCH.
//   13..all-ones-1 undefined -> illegal trap.
//  MEM_WAIT: rd_en/wr_en held high until mem_ack; mem_ack sampled same cycle it is high;
//   mem_ack in EXEC (same cycle as request) completes immediately. Wait counter reaching
//   MEM_TO with no ack -> HALT, timeout=1, rd_en/wr_en drop. mem_ack outside a request ignored.
//  HALT: all strobes 0, halted=1; exit only by reset. illegal/timeout mutually exclusive.
//  At most one of loadPC/incPC and one of rd_en/wr_en high in any cycle.
// TESTING
//  Reset then opcode 0x01 -> loadIR@FETCH, alu_op=0x01 in EXEC+WB, loadacc in 4th cycle only.
//  ALU_LAT=3, opcode 0x03 -> EXEC 3 cycles, loadacc on 6th cycle, next loadIR on 7th.
//  0x85 with c=1 -> loadPC=1,selPC=0 in EXEC; c=0 -> no loadPC, FETCH next; 0x8C,z=0,ack
//   after 4 cycles -> rd_en high 5 cycles, loadPC+selPC=1 with ack.
//  0x83, mem_ack never -> wr_en high MEM_TO cycles, then halted=1,timeout=1,wr_en=0.
//  0x04 and 0x8D -> illegal=1,halted=1; rstn=1 pulse -> all flags clear, FETCH resumes.
//  rstn asserted during MEM_WAIT of 0x84 -> rd_en 0 next cycle, no loadacc, restart at FETCH.

Source files
------------

// File: rtl/control_flow_seq_if.sv
// Control bus between the sequencer and the accumulator-machine datapath.
// master = sequencer side, slave = datapath / IR / flag side.
interface control_flow_seq_if #(
  parameter int OPW = 8
);
  logic [OPW-1:0] opcode;
  logic           z;
  logic           c;
  logic           mem_ack;
  logic           loadIR;
  logic           incPC;
  logic           loadPC;
  logic           selPC;
  logic [1:0]     selacc;
  logic           loadacc;
  logic           rd_en;
  logic           wr_en;
  logic [OPW-1:0] alu_op;
  logic           halted;
  logic           illegal;
  logic           timeout;

  modport master (
    input  opcode, z, c, mem_ack,
    output loadIR, incPC, loadPC, selPC, selacc, loadacc,
           rd_en, wr_en, alu_op, halted, illegal, timeout
  );

  modport slave (
    output opcode, z, c, mem_ack,
    input  loadIR, incPC, loadPC, selPC, selacc, loadacc,
           rd_en, wr_en, alu_op, halted, illegal, timeout
  );
endinterface

// File: rtl/control_flow_seq.sv
// Fetch/decode/execute/writeback sequencer for the accumulator machine, with
// multi-cycle ALU ops, acked memory accesses with timeout, HALT and illegal trap.
module control_flow_seq #(
  parameter int OPW     = 8,
  parameter int ALU_LAT = 1,
  parameter int MEM_TO  = 16
) (
  input  logic                clk,
  input  logic                rstn,
  control_flow_seq_if.master  bus
);
  localparam int LW = OPW - 1;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, MEM_WAIT, HALT} state_t;

  state_t         state_r;
  logic [7:0]     cnt_r;
  logic [OPW-1:0] op_r;
  logic           load_ir_r, inc_pc_r, load_pc_r, sel_pc_r;
  logic [1:0]     selacc_r;
  logic           load_acc_r, rd_en_r, wr_en_r;
  logic [OPW-1:0] alu_op_r;
  logic           halted_r, illegal_r, timeout_r;
  logic           ack_acc_r, ack_pc_r;

  logic [LW-1:0]  low_s;
  logic           cls_s, legal_s, taken_s;

  assign low_s = bus.opcode[LW-1:0];
  assign cls_s = bus.opcode[OPW-1];

  // Opcode legality and branch condition, evaluated while in DECODE.
  always_comb begin
    legal_s = 1'b0;
    taken_s = 1'b0;
    if (!cls_s) begin
      legal_s = (low_s inside {[LW'(1):LW'(3)], [LW'(5):LW'(10)]});
    end else begin
      legal_s = (low_s >= LW'(1)) && (low_s <= LW'(12));
      case (low_s)
        LW'(5), LW'(6):   taken_s = bus.c;
        LW'(7), LW'(8):   taken_s = bus.z;
        LW'(9), LW'(10):  taken_s = ~bus.c;
        LW'(11), LW'(12): taken_s = ~bus.z;
        default:          taken_s = 1'b0;
      endcase
    end
  end

  // Sequencer: outputs are registered from the state being entered.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_r    <= FETCH;
      cnt_r      <= 8'd0;
      op_r       <= '0;
      load_ir_r  <= 1'b0;
      inc_pc_r   <= 1'b0;
      load_pc_r  <= 1'b0;
      sel_pc_r   <= 1'b0;
      selacc_r   <= 2'b11;
      load_acc_r <= 1'b0;
      rd_en_r    <= 1'b0;
      wr_en_r    <= 1'b0;
      alu_op_r   <= '0;
      halted_r   <= 1'b0;
      illegal_r  <= 1'b0;
      timeout_r  <= 1'b0;
      ack_acc_r  <= 1'b0;
      ack_pc_r   <= 1'b0;
    end else begin
      load_ir_r  <= 1'b0;
      inc_pc_r   <= 1'b0;
      load_pc_r  <= 1'b0;
      sel_pc_r   <= 1'b0;
      selacc_r   <= 2'b11;
      load_acc_r <= 1'b0;
      rd_en_r    <= 1'b0;
      wr_en_r    <= 1'b0;
      alu_op_r   <= '0;
      ack_acc_r  <= 1'b0;
      ack_pc_r   <= 1'b0;
      case (state_r)
        FETCH: begin
          // The first cycle out of reset has not yet issued its fetch strobes.
          if (!load_ir_r) begin
            load_ir_r <= 1'b1;
            inc_pc_r  <= 1'b1;
          end else begin
            state_r <= DECODE;
          end
        end
        DECODE: begin
          op_r <= bus.opcode;
          cnt_r <= 8'd0;
          if (bus.opcode == '0) begin
            state_r   <= FETCH;
            load_ir_r <= 1'b1;
            inc_pc_r  <= 1'b1;
          end else if (&bus.opcode) begin
            state_r  <= HALT;
            halted_r <= 1'b1;
          end else if (!legal_s) begin
            state_r   <= HALT;
            halted_r  <= 1'b1;
            illegal_r <= 1'b1;
          end else begin
            state_r <= EXEC;
            if (!cls_s) begin
              alu_op_r <= bus.opcode;
            end else begin
              case (low_s)
                LW'(1): begin
                  selacc_r   <= 2'b01;
                  load_acc_r <= 1'b1;
                end
                LW'(2), LW'(4): begin
                  rd_en_r   <= 1'b1;
                  selacc_r  <= 2'b10;
                  ack_acc_r <= 1'b1;
                end
                LW'(3): wr_en_r <= 1'b1;
                default: begin
                  if (taken_s && low_s[0]) begin
                    load_pc_r <= 1'b1;
                  end else if (taken_s) begin
                    rd_en_r  <= 1'b1;
                    sel_pc_r <= 1'b1;
                    ack_pc_r <= 1'b1;
                  end else begin
                    load_pc_r <= 1'b0;
                  end
                end
              endcase
            end
          end
        end
        EXEC, MEM_WAIT: begin
          if ((state_r == EXEC) && !op_r[OPW-1]) begin
            alu_op_r <= op_r;
            if (cnt_r == 8'(ALU_LAT - 1)) begin
              state_r    <= WB;
              selacc_r   <= 2'b00;
              load_acc_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + 8'd1;
            end
          end else if (!(rd_en_r || wr_en_r) || bus.mem_ack) begin
            state_r   <= FETCH;
            load_ir_r <= 1'b1;
            inc_pc_r  <= 1'b1;
          end else if ((state_r == MEM_WAIT) && (cnt_r == 8'(MEM_TO - 1))) begin
            state_r   <= HALT;
            halted_r  <= 1'b1;
            timeout_r <= 1'b1;
          end else begin
            // Keep the request and its completion action armed until acked.
            state_r   <= MEM_WAIT;
            cnt_r     <= cnt_r + 8'd1;
            rd_en_r   <= rd_en_r;
            wr_en_r   <= wr_en_r;
            sel_pc_r  <= sel_pc_r;
            selacc_r  <= selacc_r;
            ack_acc_r <= ack_acc_r;
            ack_pc_r  <= ack_pc_r;
          end
        end
        WB: begin
          state_r   <= FETCH;
          load_ir_r <= 1'b1;
          inc_pc_r  <= 1'b1;
        end
        HALT: begin
          halted_r <= 1'b1;
        end
        default: begin
          state_r <= FETCH;
        end
      endcase
    end
  end

  // Memory data is consumed in the cycle the ack arrives.
  assign bus.loadacc = load_acc_r | (ack_acc_r & bus.mem_ack);
  assign bus.loadPC  = load_pc_r | (ack_pc_r & bus.mem_ack);
  assign bus.loadIR  = load_ir_r;
  assign bus.incPC   = inc_pc_r;
  assign bus.selPC   = sel_pc_r;
  assign bus.selacc  = selacc_r;
  assign bus.rd_en   = rd_en_r;
  assign bus.wr_en   = wr_en_r;
  assign bus.alu_op  = alu_op_r;
  assign bus.halted  = halted_r;
  assign bus.illegal = illegal_r;
  assign bus.timeout = timeout_r;
endmodule

// File: tb/tb_control_flow_seq.sv
// Scoreboard bench: stimulus queues the hand-computed per-cycle control word,
// a negedge monitor pops and compares against the DUT outputs.
module tb_control_flow_seq;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic [7:0] opcode = 8'h00;
  logic z = 1'b0, c = 1'b0, ack = 1'b0;
  bit   sel3 = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  typedef struct {
    string       nm;
    logic [18:0] v;
  } exp_t;

  exp_t q[$];
  exp_t q3[$];
  exp_t e, e3;
  logic [18:0] got, got3;

  control_flow_seq_if #(.OPW(8)) bus();
  control_flow_seq_if #(.OPW(8)) bus3();

  assign bus.opcode   = opcode;
  assign bus.z        = z;
  assign bus.c        = c;
  assign bus.mem_ack  = ack;
  assign bus3.opcode  = opcode;
  assign bus3.z       = z;
  assign bus3.c       = c;
  assign bus3.mem_ack = ack;

  control_flow_seq #(.OPW(8), .ALU_LAT(1), .MEM_TO(16)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  control_flow_seq #(.OPW(8), .ALU_LAT(3), .MEM_TO(16)) dut3 (.clk(clk), .rstn(rstn), .bus(bus3));

  always #5 clk = ~clk;

  function automatic logic [18:0] v(input logic ir, input logic inc, input logic lpc,
                                    input logic spc, input logic [1:0] sa, input logic la,
                                    input logic rd, input logic wr, input logic [7:0] aop,
                                    input logic h, input logic il, input logic to);
    return {ir, inc, lpc, spc, sa, la, rd, wr, aop, h, il, to};
  endfunction

  function automatic logic [18:0] exv(input logic [7:0] op);
    return v(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, op, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [18:0] wbv(input logic [7:0] op);
    return v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, op, 1'b0, 1'b0, 1'b0);
  endfunction

  logic [18:0] IDLE, FET, JMPI, JWAIT, JACK, MOVI, LDW, LDACK, STW, HTO, HIL, HLT;

  // Monitor: one comparison per queued expectation, per DUT.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      got = {bus.loadIR, bus.incPC, bus.loadPC, bus.selPC, bus.selacc, bus.loadacc,
             bus.rd_en, bus.wr_en, bus.alu_op, bus.halted, bus.illegal, bus.timeout};
      n_checks++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.nm, got, e.v);
      end
    end
    if (q3.size() > 0) begin
      e3 = q3.pop_front();
      got3 = {bus3.loadIR, bus3.incPC, bus3.loadPC, bus3.selPC, bus3.selacc, bus3.loadacc,
              bus3.rd_en, bus3.wr_en, bus3.alu_op, bus3.halted, bus3.illegal, bus3.timeout};
      n_checks++;
      if (got3 !== e3.v) begin
        n_fail++;
        $display("FAIL lat3_%s: got %h expected %h", e3.nm, got3, e3.v);
      end
    end
  end

  task automatic chk(input string nm, input logic [18:0] ev);
    exp_t t;
    t.nm = nm;
    t.v  = ev;
    if (sel3) q3.push_back(t);
    else      q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    chk("reset", IDLE);
    chk("fetch", FET);
  endtask

  initial begin
    IDLE  = v(0, 0, 0, 0, 2'b11, 0, 0, 0, 8'h00, 0, 0, 0);
    FET   = v(1, 1, 0, 0, 2'b11, 0, 0, 0, 8'h00, 0, 0, 0);
    JMPI  = v(0, 0, 1, 0, 2'b11, 0, 0, 0, 8'h00, 0, 0, 0);
    JWAIT = v(0, 0, 0, 1, 2'b11, 0, 1, 0, 8'h00, 0, 0, 0);
    JACK  = v(0, 0, 1, 1, 2'b11, 0, 1, 0, 8'h00, 0, 0, 0);
    MOVI  = v(0, 0, 0, 0, 2'b01, 1, 0, 0, 8'h00, 0, 0, 0);
    LDW   = v(0, 0, 0, 0, 2'b10, 0, 1, 0, 8'h00, 0, 0, 0);
    LDACK = v(0, 0, 0, 0, 2'b10, 1, 1, 0, 8'h00, 0, 0, 0);
    STW   = v(0, 0, 0, 0, 2'b11, 0, 0, 1, 8'h00, 0, 0, 0);
    HTO   = v(0, 0, 0, 0, 2'b11, 0, 0, 0, 8'h00, 1, 0, 1);
    HIL   = v(0, 0, 0, 0, 2'b11, 0, 0, 0, 8'h00, 1, 1, 0);
    HLT   = v(0, 0, 0, 0, 2'b11, 0, 0, 0, 8'h00, 1, 0, 0);

    do_reset();
    // ADD at ALU_LAT=1: four cycles, loadacc only in WB
    opcode = 8'h01;
    chk("add_dec", IDLE); chk("add_exec", exv(8'h01)); chk("add_wb", wbv(8'h01));
    chk("add_fetch", FET);
    opcode = 8'h00;
    chk("nop_dec", IDLE); chk("nop_fetch", FET);
    // JC imm taken, flag changing after entry to EXEC must not matter
    opcode = 8'h85; c = 1'b1;
    chk("jc_dec", IDLE); c = 1'b0;
    chk("jc_exec", JMPI); chk("jc_fetch", FET);
    chk("jcn_dec", IDLE); chk("jcn_exec", IDLE); chk("jcn_fetch", FET);
    // JNZ addr, ack in the fifth request cycle
    opcode = 8'h8C; z = 1'b0;
    chk("jnz_dec", IDLE); z = 1'b1;
    chk("jnz_exec", JWAIT);
    repeat (3) chk("jnz_wait", JWAIT);
    ack = 1'b1;
    chk("jnz_ack", JACK);
    ack = 1'b0; z = 1'b0;
    chk("jnz_fetch", FET);
    opcode = 8'h81;
    chk("movi_dec", IDLE); chk("movi_exec", MOVI); chk("movi_fetch", FET);
    // LOAD completed by an ack in the request cycle itself
    opcode = 8'h84;
    chk("ld_dec", IDLE); ack = 1'b1;
    chk("ld_exec_ack", LDACK); ack = 1'b0;
    chk("ld_fetch", FET);
    // STORE never acked: MEM_TO request cycles then timeout HALT
    opcode = 8'h83;
    chk("st_dec", IDLE);
    repeat (16) chk("st_wait", STW);
    chk("st_timeout", HTO); ack = 1'b1;
    chk("st_halt_hold", HTO); ack = 1'b0;

    do_reset();
    opcode = 8'h04;
    chk("ill4_dec", IDLE); chk("ill4_halt", HIL); chk("ill4_hold", HIL);
    do_reset();
    opcode = 8'h8D;
    chk("ill8d_dec", IDLE); chk("ill8d_halt", HIL);
    do_reset();
    opcode = 8'hFF;
    chk("halt_dec", IDLE); chk("halt_state", HLT);
    // Reset in the middle of a LOAD wait aborts it
    do_reset();
    opcode = 8'h84;
    chk("abort_dec", IDLE); chk("abort_exec", LDW); chk("abort_wait1", LDW);
    rstn = 1'b1;
    chk("abort_wait2", LDW);
    rstn = 1'b0; ack = 1'b1;
    chk("abort_reset", IDLE); chk("abort_fetch", FET);
    ack = 1'b0;

    // ALU_LAT=3 instance: three EXEC cycles, loadacc on cycle 6, fetch on 7
    sel3 = 1'b1;
    do_reset();
    opcode = 8'h03;
    chk("mul_dec", IDLE);
    repeat (3) chk("mul_exec", exv(8'h03));
    chk("mul_wb", wbv(8'h03)); chk("mul_fetch", FET);
    sel3 = 1'b0;

    for (int i = 0; i < 10 && (q.size() > 0 || q3.size() > 0); i++) @(negedge clk);
    if (q.size() > 0 || q3.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size() + q3.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
